id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32 pipeline, directly downstream of the decode-stage control unit.
- Registers that unit's control outputs together with the decoded operands, immediate, funct bits and register addresses for the EX stage.
- Owns load-use hazard detection. Its NoOp_o feeds back into the control unit's NoOp_i and freezes PC and IF/ID.
- Handles flush (taken branch), external stall (memory wait) and bubble insertion, and keeps a saturating bubble counter for performance analysis.

Parameters:
- DATA_W, 32, width of operand and immediate fields
- CNT_W, 16, width of bubble counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- Stall_i  in  1  hold all state (memory wait)
- Flush_i  in  1  taken branch: squash the instruction being captured
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i  in  1 each  decode control
- ALUOp_i  in  2  decode ALU op class
- RS1data_i, RS2data_i  in  DATA_W  register-file read data
- Imm_i  in  DATA_W  sign-extended immediate
- Funct_i  in  10  {funct7, funct3}
- RS1addr_i, RS2addr_i, RDaddr_i  in  5 each  decode-stage register addresses
- RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o  out  1 each  EX control
- ALUOp_o  out  2  EX ALU op class
- RS1data_o, RS2data_o, Imm_o  out  DATA_W  EX operands
- Funct_o  out  10  EX funct bits
- RS1addr_o, RS2addr_o, RDaddr_o  out  5 each  for forwarding unit
- Valid_o  out  1  EX slot holds a real instruction
- NoOp_o  out  1  load-use hazard, goes to control NoOp_i
- PCWrite_o, IFIDWrite_o  out  1 each  enable PC / IF/ID update
- BubbleCnt_o  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset (rst_i low, asynchronous): every registered output is 0, including Valid_o and BubbleCnt_o.
- Latency: 1 cycle. Inputs present at rising edge N appear on the outputs after edge N.
- Hazard detection is combinational from registered state and current decode addresses:
  - Hazard = Valid_o & MemRead_o & (RDaddr_o != 0) & ((RDaddr_o == RS1addr_i) | (RDaddr_o == RS2addr_i)).
  - Both sources are always compared, regardless of instruction type. Spurious stalls are accepted.
- NoOp_o = Hazard & ~Flush_i.
- PCWrite_o = IFIDWrite_o = ~NoOp_o & ~Stall_i.
- Per-edge priority, highest first:
  1. Flush_i: load bubble. All control outputs 0, Valid_o 0, data and address fields 0. Counter increments.
  2. Stall_i: hold every register. Counter unchanged.
  3. Hazard: load bubble, same as flush. Counter increments. Applied even though the control inputs are already zeroed through NoOp_i.
  4. Otherwise: capture all inputs and set Valid_o = 1.
- Write to x0: on a normal capture, RegWrite_o = RegWrite_i & (RDaddr_i != 0).
- BubbleCnt_o saturates at all-ones and never wraps.
- Flush_i and Stall_i together: flush wins and a bubble is loaded. The frozen IF/ID is discarded upstream.
- Hazard and Stall_i together: state holds, NoOp_o stays asserted, and the bubble is inserted on the first edge without Stall_i.
- Back-to-back loads to the same rd: exactly one bubble per dependent consumer, then the hazard clears because Valid_o = 0.
- Reset mid-stall or mid-hazard: outputs clear immediately. The first edge after release captures normally.

Decomposition:
- Shared package pipe_pkg holds:
  - ALUOp encodings: ALUOP_ADD=2'b00, ALUOP_BR=2'b01, ALUOP_R=2'b10
  - opcode constants: R=7'b0110011, I=7'b0010011, LW=7'b0000011, SW=7'b0100011, BEQ=7'b1100011
  - a packed ex_ctrl struct: RegWrite, MemtoReg, MemRead, MemWrite, ALUOp, ALUSrc
- One sub-module: hazard_detect, a purely combinational block producing Hazard, NoOp_o, PCWrite_o and IFIDWrite_o.

Test Plan:
- Reset release, then `add x3,x1,x2` (RegWrite_i=1, ALUOp_i=10, RDaddr_i=3) → next cycle: RegWrite_o=1, ALUOp_o=10, RDaddr_o=3, Valid_o=1, BubbleCnt_o=0.
- Load-use: `lw x5` captured (MemRead_o=1, RDaddr_o=5), decode has RS2addr_i=5 → NoOp_o=1 and PCWrite_o=0 the same cycle; next edge gives Valid_o=0, all control 0, BubbleCnt_o=1; NoOp_o then 0.
- `lw x0` followed by a user of x0 → NoOp_o=0, no bubble. `addi x0` capture → RegWrite_o=0.
- Flush_i=1 together with Stall_i=1 while a valid sw is decoded → MemWrite_o=0, Valid_o=0, BubbleCnt_o increments by 1.
- Hazard present with Stall_i held 3 cycles → outputs frozen, NoOp_o=1 throughout; one bubble after Stall_i drops; count +1 only.
- Force CNT_W=4 and generate 20 flushes → BubbleCnt_o=15, stays 15. Assert rst_i mid-sequence → all outputs 0 asynchronously.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU op classes, base opcodes and the EX-stage
// control bundle registered by the ID/EX stage.
package pipe_pkg;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef struct packed {
    logic       RegWrite;
    logic       MemtoReg;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] ALUOp;
    logic       ALUSrc;
  } ex_ctrl_t;

  // A bubble is an all-zero control word: no writes, no memory access.
  function automatic ex_ctrl_t ctrl_bubble();
    return '0;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle. master = decode/control side, slave = ID/EX stage.
// Stall_i/Flush_i are level controls sampled on every rising edge; there is no
// valid/ready pair -- NoOp_o/PCWrite_o/IFIDWrite_o are the backpressure path.
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              Stall_i, Flush_i;
  logic              RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
  logic [1:0]        ALUOp_i;
  logic [DATA_W-1:0] RS1data_i, RS2data_i, Imm_i;
  logic [9:0]        Funct_i;
  logic [4:0]        RS1addr_i, RS2addr_i, RDaddr_i;

  logic              RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o;
  logic [1:0]        ALUOp_o;
  logic [DATA_W-1:0] RS1data_o, RS2data_o, Imm_o;
  logic [9:0]        Funct_o;
  logic [4:0]        RS1addr_o, RS2addr_o, RDaddr_o;
  logic              Valid_o, NoOp_o, PCWrite_o, IFIDWrite_o;
  logic [CNT_W-1:0]  BubbleCnt_o;

  modport master (
    output Stall_i, Flush_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
           ALUSrc_i, ALUOp_i, RS1data_i, RS2data_i, Imm_i, Funct_i,
           RS1addr_i, RS2addr_i, RDaddr_i,
    input  RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o,
           RS1data_o, RS2data_o, Imm_o, Funct_o, RS1addr_o, RS2addr_o,
           RDaddr_o, Valid_o, NoOp_o, PCWrite_o, IFIDWrite_o, BubbleCnt_o
  );

  modport slave (
    input  Stall_i, Flush_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
           ALUSrc_i, ALUOp_i, RS1data_i, RS2data_i, Imm_i, Funct_i,
           RS1addr_i, RS2addr_i, RDaddr_i,
    output RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o,
           RS1data_o, RS2data_o, Imm_o, Funct_o, RS1addr_o, RS2addr_o,
           RDaddr_o, Valid_o, NoOp_o, PCWrite_o, IFIDWrite_o, BubbleCnt_o
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: compares the load sitting in EX against both
// source addresses currently in decode. Purely combinational.
module hazard_detect (
  input  logic       valid_q_i,
  input  logic       memread_q_i,
  input  logic [4:0] rd_q_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       stall_i,
  input  logic       flush_i,
  output logic       hazard_o,
  output logic       noop_o,
  output logic       pcwrite_o,
  output logic       ifidwrite_o
);

  // Both sources are compared even for formats that lack rs2; a spurious
  // one-cycle bubble is cheaper than decoding the format here.
  assign hazard_o    = valid_q_i & memread_q_i & (rd_q_i != 5'd0) &
                       ((rd_q_i == rs1_i) | (rd_q_i == rs2_i));
  assign noop_o      = hazard_o & ~flush_i;
  assign pcwrite_o   = ~noop_o & ~stall_i;
  assign ifidwrite_o = ~noop_o & ~stall_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, stall and a
// saturating count of inserted bubbles.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic    clk_i,
  input  logic    rst_i,
  id_ex_if.slave  bus
);

  ex_ctrl_t          ctrl_q, ctrl_d;
  logic [DATA_W-1:0] rs1data_q, rs1data_d, rs2data_q, rs2data_d, imm_q, imm_d;
  logic [9:0]        funct_q, funct_d;
  logic [4:0]        rs1addr_q, rs1addr_d, rs2addr_q, rs2addr_d, rdaddr_q, rdaddr_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hazard, bubble;

  hazard_detect u_hazard (
    .valid_q_i   (valid_q),
    .memread_q_i (ctrl_q.MemRead),
    .rd_q_i      (rdaddr_q),
    .rs1_i       (bus.RS1addr_i),
    .rs2_i       (bus.RS2addr_i),
    .stall_i     (bus.Stall_i),
    .flush_i     (bus.Flush_i),
    .hazard_o    (hazard),
    .noop_o      (bus.NoOp_o),
    .pcwrite_o   (bus.PCWrite_o),
    .ifidwrite_o (bus.IFIDWrite_o)
  );

  // Flush beats stall beats hazard; the hazard bubble is loaded even though the
  // control unit has already zeroed its outputs via NoOp.
  always_comb begin
    ctrl_d    = ctrl_q;
    rs1data_d = rs1data_q;
    rs2data_d = rs2data_q;
    imm_d     = imm_q;
    funct_d   = funct_q;
    rs1addr_d = rs1addr_q;
    rs2addr_d = rs2addr_q;
    rdaddr_d  = rdaddr_q;
    valid_d   = valid_q;
    bubble    = 1'b0;
    if (bus.Flush_i || (!bus.Stall_i && hazard)) begin
      bubble    = 1'b1;
      ctrl_d    = ctrl_bubble();
      rs1data_d = '0;
      rs2data_d = '0;
      imm_d     = '0;
      funct_d   = '0;
      rs1addr_d = '0;
      rs2addr_d = '0;
      rdaddr_d  = '0;
      valid_d   = 1'b0;
    end else if (!bus.Stall_i) begin
      ctrl_d.RegWrite = bus.RegWrite_i & (bus.RDaddr_i != 5'd0);
      ctrl_d.MemtoReg = bus.MemtoReg_i;
      ctrl_d.MemRead  = bus.MemRead_i;
      ctrl_d.MemWrite = bus.MemWrite_i;
      ctrl_d.ALUOp    = bus.ALUOp_i;
      ctrl_d.ALUSrc   = bus.ALUSrc_i;
      rs1data_d       = bus.RS1data_i;
      rs2data_d       = bus.RS2data_i;
      imm_d           = bus.Imm_i;
      funct_d         = bus.Funct_i;
      rs1addr_d       = bus.RS1addr_i;
      rs2addr_d       = bus.RS2addr_i;
      rdaddr_d        = bus.RDaddr_i;
      valid_d         = 1'b1;
    end
    cnt_d = (bubble && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q    <= '0;
      rs1data_q <= '0;
      rs2data_q <= '0;
      imm_q     <= '0;
      funct_q   <= '0;
      rs1addr_q <= '0;
      rs2addr_q <= '0;
      rdaddr_q  <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs1data_q <= rs1data_d;
      rs2data_q <= rs2data_d;
      imm_q     <= imm_d;
      funct_q   <= funct_d;
      rs1addr_q <= rs1addr_d;
      rs2addr_q <= rs2addr_d;
      rdaddr_q  <= rdaddr_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.RegWrite_o  = ctrl_q.RegWrite;
  assign bus.MemtoReg_o  = ctrl_q.MemtoReg;
  assign bus.MemRead_o   = ctrl_q.MemRead;
  assign bus.MemWrite_o  = ctrl_q.MemWrite;
  assign bus.ALUOp_o     = ctrl_q.ALUOp;
  assign bus.ALUSrc_o    = ctrl_q.ALUSrc;
  assign bus.RS1data_o   = rs1data_q;
  assign bus.RS2data_o   = rs2data_q;
  assign bus.Imm_o       = imm_q;
  assign bus.Funct_o     = funct_q;
  assign bus.RS1addr_o   = rs1addr_q;
  assign bus.RS2addr_o   = rs2addr_q;
  assign bus.RDaddr_o    = rdaddr_q;
  assign bus.Valid_o     = valid_q;
  assign bus.BubbleCnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus randomized bench for id_ex_stage with a slot-level reference
// model; a second instance with a 4-bit counter covers saturation.
module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam int OUT_W = 145;

  typedef struct packed {
    logic        rw, mtr, mr, mw, as;
    logic [1:0]  aluop;
    logic [31:0] d1, d2, imm;
    logic [9:0]  funct;
    logic [4:0]  rs1, rs2, rd;
  } in_t;

  typedef struct packed {
    logic        rw, mtr, mr, mw, as;
    logic [1:0]  aluop;
    logic [31:0] d1, d2, imm;
    logic [9:0]  funct;
    logic [4:0]  rs1, rs2, rd;
    logic        valid;
  } slot_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  id_ex_if #(.DATA_W(32), .CNT_W(16)) bus ();
  id_ex_if #(.DATA_W(32), .CNT_W(4))  sbus ();

  id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  id_ex_stage #(.DATA_W(32), .CNT_W(4))  dut_small (.clk_i(clk_i), .rst_i(rst_i), .bus(sbus));

  int checks = 0;
  int errors = 0;
  logic [OUT_W-1:0] exp_q[$];
  in_t   cur;
  slot_t m;
  int    m_cnt;

  task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] obs_vec();
    return {bus.RegWrite_o, bus.MemtoReg_o, bus.MemRead_o, bus.MemWrite_o, bus.ALUSrc_o,
            bus.ALUOp_o, bus.RS1data_o, bus.RS2data_o, bus.Imm_o, bus.Funct_o,
            bus.RS1addr_o, bus.RS2addr_o, bus.RDaddr_o, bus.Valid_o, bus.BubbleCnt_o};
  endfunction

  task automatic drive(input logic st, input logic fl);
    bus.Stall_i    = st;
    bus.Flush_i    = fl;
    bus.RegWrite_i = cur.rw;
    bus.MemtoReg_i = cur.mtr;
    bus.MemRead_i  = cur.mr;
    bus.MemWrite_i = cur.mw;
    bus.ALUSrc_i   = cur.as;
    bus.ALUOp_i    = cur.aluop;
    bus.RS1data_i  = cur.d1;
    bus.RS2data_i  = cur.d2;
    bus.Imm_i      = cur.imm;
    bus.Funct_i    = cur.funct;
    bus.RS1addr_i  = cur.rs1;
    bus.RS2addr_i  = cur.rs2;
    bus.RDaddr_i   = cur.rd;
  endtask

  task automatic new_instr(input logic rw, mtr, mr, mw, as, input logic [1:0] aluop,
                           input logic [4:0] rs1, rs2, rd);
    cur       = '0;
    cur.rw    = rw;  cur.mtr = mtr; cur.mr = mr; cur.mw = mw; cur.as = as;
    cur.aluop = aluop;
    cur.rs1   = rs1; cur.rs2 = rs2; cur.rd = rd;
    cur.d1    = $urandom;
    cur.d2    = $urandom;
    cur.imm   = $urandom;
    cur.funct = 10'($urandom);
  endtask

  // The EX slot is a loaded consumer-blocker when it holds a real load to a
  // nonzero register that decode wants to read.
  function automatic logic model_hazard();
    return m.valid && m.mr && (m.rd != 5'd0) && (m.rd == cur.rs1 || m.rd == cur.rs2);
  endfunction

  function automatic void model_bubble();
    m = '0;
    if (m_cnt < 65535) m_cnt++;
  endfunction

  task automatic step(input logic st, input logic fl, input string tag);
    logic haz, noop, adv;
    @(negedge clk_i);
    drive(st, fl);
    #1;
    haz  = model_hazard();
    noop = haz && !fl;
    adv  = !noop && !st;
    check({tag, "_noop"}, OUT_W'(bus.NoOp_o), OUT_W'(noop));
    check({tag, "_pcw"}, OUT_W'(bus.PCWrite_o), OUT_W'(adv));
    check({tag, "_ifidw"}, OUT_W'(bus.IFIDWrite_o), OUT_W'(adv));
    if (fl) model_bubble();
    else if (!st) begin
      if (haz) model_bubble();
      else begin
        m.rw = cur.rw && (cur.rd != 5'd0);
        m.mtr = cur.mtr; m.mr = cur.mr; m.mw = cur.mw; m.as = cur.as;
        m.aluop = cur.aluop; m.d1 = cur.d1; m.d2 = cur.d2; m.imm = cur.imm;
        m.funct = cur.funct; m.rs1 = cur.rs1; m.rs2 = cur.rs2; m.rd = cur.rd;
        m.valid = 1'b1;
      end
    end
    exp_q.push_back({m, 16'(m_cnt)});
    @(posedge clk_i);
    #1;
    check({tag, "_out"}, obs_vec(), exp_q.pop_front());
  endtask

  task automatic model_reset();
    m = '0;
    m_cnt = 0;
  endtask

  initial begin
    int small_exp;
    sbus.Stall_i = 0; sbus.Flush_i = 0; sbus.RegWrite_i = 0; sbus.MemtoReg_i = 0;
    sbus.MemRead_i = 0; sbus.MemWrite_i = 0; sbus.ALUSrc_i = 0; sbus.ALUOp_i = '0;
    sbus.RS1data_i = '0; sbus.RS2data_i = '0; sbus.Imm_i = '0; sbus.Funct_i = '0;
    sbus.RS1addr_i = '0; sbus.RS2addr_i = '0; sbus.RDaddr_i = '0;
    cur = '0;
    drive(1'b0, 1'b0);
    model_reset();

    repeat (2) @(posedge clk_i);
    #1;
    check("reset_out", obs_vec(), '0);
    check("reset_noop", OUT_W'(bus.NoOp_o), '0);
    @(negedge clk_i);
    rst_i = 1'b1;

    new_instr(1, 0, 0, 0, 0, ALUOP_R, 5'd1, 5'd2, 5'd3);
    step(0, 0, "add_x3");
    new_instr(1, 1, 1, 0, 1, ALUOP_ADD, 5'd2, 5'd0, 5'd5);
    step(0, 0, "lw_x5");
    new_instr(1, 0, 0, 0, 0, ALUOP_R, 5'd4, 5'd5, 5'd6);
    step(0, 0, "use_x5_bubble");
    step(0, 0, "use_x5_go");

    new_instr(1, 1, 1, 0, 1, ALUOP_ADD, 5'd1, 5'd0, 5'd0);
    step(0, 0, "lw_x0");
    new_instr(1, 0, 0, 0, 0, ALUOP_R, 5'd0, 5'd0, 5'd7);
    step(0, 0, "use_x0");
    new_instr(1, 0, 0, 0, 1, ALUOP_ADD, 5'd1, 5'd0, 5'd0);
    step(0, 0, "addi_x0");

    new_instr(0, 0, 0, 1, 1, ALUOP_ADD, 5'd1, 5'd2, 5'd0);
    step(0, 0, "sw_cap");
    step(1, 1, "flush_stall");

    new_instr(1, 1, 1, 0, 1, ALUOP_ADD, 5'd3, 5'd0, 5'd7);
    step(0, 0, "lw_x7");
    new_instr(1, 0, 0, 0, 0, ALUOP_R, 5'd7, 5'd1, 5'd8);
    for (int i = 0; i < 3; i++) step(1, 0, "haz_stall");
    step(0, 0, "haz_release");
    step(0, 0, "haz_consume");

    for (int i = 0; i < 300; i++) begin
      new_instr(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)));
      step(($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0), "rand");
    end

    new_instr(1, 1, 1, 0, 1, ALUOP_ADD, 5'd1, 5'd0, 5'd9);
    step(0, 0, "lw_x9");
    new_instr(1, 0, 0, 0, 0, ALUOP_R, 5'd1, 5'd9, 5'd10);
    step(1, 0, "haz_stall2");
    #2;
    rst_i = 1'b0;
    #1;
    model_reset();
    check("midrst_out", obs_vec(), '0);
    check("midrst_noop", OUT_W'(bus.NoOp_o), '0);
    @(negedge clk_i);
    rst_i = 1'b1;
    step(0, 0, "post_rst_cap");

    drive(1'b1, 1'b0);
    small_exp = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      sbus.Flush_i = 1'b1;
      @(posedge clk_i);
      #1;
      if (small_exp < 15) small_exp++;
      check("sat_cnt", OUT_W'(sbus.BubbleCnt_o), OUT_W'(small_exp));
    end
    check("sat_valid", OUT_W'(sbus.Valid_o), '0);
    #2;
    rst_i = 1'b0;
    #1;
    check("sat_rst_cnt", OUT_W'(sbus.BubbleCnt_o), '0);
    @(negedge clk_i);
    sbus.Flush_i = 1'b0;
    rst_i = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
